fetch_front_end: RTL
====================

Name: fetch_front_end

Overview:
Pipeline front end that consumes the stall/flush controls from the hazard detector. It owns the PC register, the next-PC selection and the IF/ID pipeline register. It honours PC write, IF/ID write and flush/branch redirect, and keeps a small state machine plus statistics counters so stall and flush behaviour can be observed. It sits between instruction memory and the ID stage.

Parameters:
PC_WIDTH, 32, width of PC, branch target and PC+4 fields
INSTR_WIDTH, 32, instruction width
RESET_PC, 0, PC value loaded on reset
NOP_INSTR, 0, instruction injected into IF/ID on flush
CNT_WIDTH, 16, width of the statistics counters (saturating)

Ports:
clk_i  in  1  clock, rising-edge
rst_i  in  1  reset, asynchronous, active-low
pc_write_i  in  1  1 = PC may advance; 0 = hold PC
ifid_write_i  in  1  1 = IF/ID may load; 0 = hold IF/ID
if_flush_i  in  1  1 = replace IF/ID contents with NOP
branch_i  in  1  taken branch/jump; redirect PC
branch_target_i  in  PC_WIDTH  redirect address
imem_instr_i  in  INSTR_WIDTH  instruction read at imem_addr_o
imem_addr_o  out  PC_WIDTH  current PC (direct from PC register)
ifid_instr_o  out  INSTR_WIDTH  IF/ID instruction
ifid_pc4_o  out  PC_WIDTH  IF/ID PC+4
ifid_valid_o  out  1  IF/ID holds a real fetched instruction
state_o  out  2  0=RUN, 1=STALL, 2=FLUSH
stall_count_o  out  CNT_WIDTH  total stall cycles
flush_count_o  out  CNT_WIDTH  total flush cycles
max_stall_o  out  CNT_WIDTH  longest consecutive stall run
misalign_o  out  1  sticky: branch target had nonzero bits [1:0]
proto_err_o  out  1  sticky: pc_write_i != ifid_write_i without flush

Behaviour:
- Reset, on rst_i low, immediately and independent of the clock:
  - PC=RESET_PC; ifid_instr_o=NOP_INSTR; ifid_pc4_o=0; ifid_valid_o=0.
  - state_o=RUN; all counters 0; misalign_o=0; proto_err_o=0.
  - Reset mid-stall or mid-flush discards all state. The first edge after release behaves as RUN.
- flush = if_flush_i OR branch_i. This is evaluated every cycle.
- Next PC, priority order:
  - branch_i: {branch_target_i[PC_WIDTH-1:2], 2'b00}. This overrides pc_write_i=0.
  - else pc_write_i: PC+4, modulo 2^PC_WIDTH. 0xFFFFFFFC wraps to 0.
  - else hold.
- IF/ID update, priority order:
  - flush: instr=NOP_INSTR, pc4=0, valid=0. This overrides ifid_write_i=0.
  - else ifid_write_i: instr=imem_instr_i, pc4=PC+4, valid=1.
  - else hold all three.
- Latency: the instruction at PC appears on ifid_instr_o one edge later. A redirect takes effect on imem_addr_o one edge after branch_i.
- State machine (registered; it records the action taken at the last edge):
  - flush -> FLUSH.
  - else (pc_write_i==0 OR ifid_write_i==0) -> STALL.
  - else -> RUN.
  - Encoding 3 is never produced.
- Counters (all saturate at 2^CNT_WIDTH-1; no wrap):
  - stall_count_o +1 on each edge whose next state is STALL.
  - flush_count_o +1 on each edge whose next state is FLUSH.
  - An internal run counter +1 per consecutive STALL edge and clears on any non-STALL edge.
  - max_stall_o = max(max_stall_o, run+1) on each STALL edge.
- misalign_o: set at the edge where branch_i=1 and branch_target_i[1:0]!=0. Cleared only by reset.
- proto_err_o: set at the edge where flush=0 and pc_write_i!=ifid_write_i. The datapath still obeys each enable independently. Cleared only by reset.
- Simultaneous branch_i and stall request: branch wins. The PC redirects, IF/ID is flushed and state is FLUSH; no stall is counted.
- X on an enable during reset is ignored. The block has no combinational path from inputs to outputs except imem_instr_i -> nothing; all outputs are registered.

Test Plan:
- Reset then 4 RUN cycles, imem returns 0x20080001.. -> imem_addr_o 0,4,8,12; ifid_pc4_o 4,8,12; valid=1 from cycle 2; state_o=0.
- PC=8, pc_write_i=ifid_write_i=0 for 3 cycles -> PC holds 8, IF/ID holds, state_o=1, stall_count_o=3, max_stall_o=3; a later 2-cycle stall leaves max_stall_o=3 and stall_count_o=5.
- branch_i=1, if_flush_i=1, target 0x40 while pc_write_i=0 -> next imem_addr_o=0x40, ifid_instr_o=NOP, valid=0, state_o=2, flush_count_o+1, stall_count_o unchanged.
- Branch target 0x42 -> PC=0x40, misalign_o=1 and it stays 1; pc_write_i=1, ifid_write_i=0 -> proto_err_o=1, PC advances, IF/ID holds.
- RESET_PC=0xFFFFFFFC, run 1 cycle -> PC=0; force stall_count to saturation -> it stays at 0xFFFF; assert rst_i low mid-stall -> all outputs at reset values without a clock edge.

Source files
------------

// File: rtl/fetch_front_end.sv
`default_nettype none
// ============================================================================
// Module      : fetch_front_end
// Description : Pipeline front end. Owns the PC, next-PC selection and the
//               IF/ID register, and reports stall/flush activity through a
//               small state machine, saturating counters and sticky errors.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_front_end #(
  parameter int                    PC_WIDTH    = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC    = '0,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR  = '0,
  parameter int                    CNT_WIDTH   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   pc_write_i,
  input  logic                   ifid_write_i,
  input  logic                   if_flush_i,
  input  logic                   branch_i,
  input  logic [PC_WIDTH-1:0]    branch_target_i,
  input  logic [INSTR_WIDTH-1:0] imem_instr_i,
  output logic [PC_WIDTH-1:0]    imem_addr_o,
  output logic [INSTR_WIDTH-1:0] ifid_instr_o,
  output logic [PC_WIDTH-1:0]    ifid_pc4_o,
  output logic                   ifid_valid_o,
  output logic [1:0]             state_o,
  output logic [CNT_WIDTH-1:0]   stall_count_o,
  output logic [CNT_WIDTH-1:0]   flush_count_o,
  output logic [CNT_WIDTH-1:0]   max_stall_o,
  output logic                   misalign_o,
  output logic                   proto_err_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [PC_WIDTH-1:0]  C_PC_STEP = PC_WIDTH'(4);
  localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = '1;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [PC_WIDTH-1:0]    r_pc;
  logic [PC_WIDTH-1:0]    w_pc4;
  logic [PC_WIDTH-1:0]    w_pc_nxt;
  logic [INSTR_WIDTH-1:0] r_ifid_instr;
  logic [PC_WIDTH-1:0]    r_ifid_pc4;
  logic                   r_ifid_valid;
  logic [CNT_WIDTH-1:0]   r_stall_cnt;
  logic [CNT_WIDTH-1:0]   r_flush_cnt;
  logic [CNT_WIDTH-1:0]   r_run_cnt;
  logic [CNT_WIDTH-1:0]   r_max_stall;
  logic [CNT_WIDTH-1:0]   w_run_inc;
  logic                   r_misalign;
  logic                   r_proto_err;
  logic                   w_flush;

  assign w_flush   = if_flush_i | branch_i;
  assign w_pc4     = r_pc + C_PC_STEP;
  // Length of the stall run including the edge being taken now, saturated.
  assign w_run_inc = (r_run_cnt == C_CNT_MAX) ? C_CNT_MAX : r_run_cnt + 1'b1;

  // Next-PC select: a redirect beats a PC-write hold.
  always_comb begin
    w_pc_nxt = r_pc;
    if (branch_i) begin
      w_pc_nxt = {branch_target_i[PC_WIDTH-1:2], 2'b00};
    end else if (pc_write_i) begin
      w_pc_nxt = w_pc4;
    end
  end

  // PC register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_pc <= RESET_PC;
    else        r_pc <= w_pc_nxt;
  end

  // IF/ID register: flush injects a NOP even when IF/ID write is held off.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ifid_instr <= NOP_INSTR;
      r_ifid_pc4   <= '0;
      r_ifid_valid <= 1'b0;
    end else if (w_flush) begin
      r_ifid_instr <= NOP_INSTR;
      r_ifid_pc4   <= '0;
      r_ifid_valid <= 1'b0;
    end else if (ifid_write_i) begin
      r_ifid_instr <= imem_instr_i;
      r_ifid_pc4   <= w_pc4;
      r_ifid_valid <= 1'b1;
    end
  end

  // State register: records the action taken at the last edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode: flush outranks a stall request.
  always_comb begin
    w_state_nxt = ST_RUN;
    if (w_flush) begin
      w_state_nxt = ST_FLUSH;
    end else if (!pc_write_i || !ifid_write_i) begin
      w_state_nxt = ST_STALL;
    end
  end

  // Saturating statistics counters driven by the next state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_run_cnt   <= '0;
      r_max_stall <= '0;
    end else begin
      if (w_state_nxt == ST_STALL) begin
        if (r_stall_cnt != C_CNT_MAX) r_stall_cnt <= r_stall_cnt + 1'b1;
        r_run_cnt <= w_run_inc;
        if (w_run_inc > r_max_stall) r_max_stall <= w_run_inc;
      end else begin
        r_run_cnt <= '0;
      end
      if (w_state_nxt == ST_FLUSH && r_flush_cnt != C_CNT_MAX) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_misalign  <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      if (branch_i && (branch_target_i[1:0] != 2'b00)) r_misalign <= 1'b1;
      if (!w_flush && (pc_write_i != ifid_write_i))     r_proto_err <= 1'b1;
    end
  end

  assign imem_addr_o   = r_pc;
  assign ifid_instr_o  = r_ifid_instr;
  assign ifid_pc4_o    = r_ifid_pc4;
  assign ifid_valid_o  = r_ifid_valid;
  assign state_o       = r_state;
  assign stall_count_o = r_stall_cnt;
  assign flush_count_o = r_flush_cnt;
  assign max_stall_o   = r_max_stall;
  assign misalign_o    = r_misalign;
  assign proto_err_o   = r_proto_err;

endmodule
`default_nettype wire
